// File: rtl/noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_arbiter
// Purpose  : Router output-port arbiter. Shares one output port between
//            NUM_IN input interfaces with round-robin arbitration. It latches
//            the winning flit into a single-entry output register, pulses the
//            winner's buffer-clear line, and forwards the flit downstream with
//            a send/ready (so/ro) handshake.
// Ports    : clk        rising-edge clock
//            rst        asynchronous, active-low reset
//            req        per-input request (input k holds a flit for this port)
//            datai      flit bus, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//            ro         downstream ready (1 = downstream buffer empty)
//            buf_clear  one-hot, one-cycle pulse to the granted input
//            so         one-cycle send strobe to downstream
//            datao      held flit, valid while HOLD or SEND
//            busy       1 whenever the arbiter is not IDLE
//            grant_cnt  (OUTARB_GRANT_STATS_EN only) 16-bit saturating grant
//                       counter per input, input k at [k*16 +: 16]
// Options  : OUTARB_GRANT_STATS_EN - adds the grant_cnt statistics port
// Revision : 1.0 - initial release
// ============================================================================
module noc_output_arbiter #(
    parameter int                DATA_WIDTH = 64,
    parameter int                NUM_IN     = 5,
    parameter logic [NUM_IN-1:0] UTURN_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] datai,
    input  logic                         ro,
    output logic [NUM_IN-1:0]            buf_clear,
    output logic                         so,
    output logic [DATA_WIDTH-1:0]        datao,
    output logic                         busy
`ifdef OUTARB_GRANT_STATS_EN
    ,
    output logic [NUM_IN*16-1:0]         grant_cnt
`endif
);

    localparam int c_PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [c_PTR_W:0]   c_NUM_IN_X = (c_PTR_W+1)'(NUM_IN);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(NUM_IN - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    logic [1:0]            r_state;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [NUM_IN-1:0]     r_buf_clear;
    logic                  r_so;
    logic [DATA_WIDTH-1:0] r_datao;

    logic [NUM_IN-1:0]     w_ereq;
    logic                  w_any;
    logic [c_PTR_W-1:0]    w_win;
    logic [c_PTR_W:0]      w_idx;
    logic [c_PTR_W-1:0]    w_ptr_next;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_slice [NUM_IN];

    // Masked inputs can never win, which blocks U-turns through this port.
    assign w_ereq = req & ~UTURN_MASK;

    genvar gi;
    for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
        assign w_slice[gi] = datai[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting at r_ptr. Offsets are scanned from the
    // farthest to the nearest so the last hit is the nearest requester,
    // which avoids an early loop exit.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
            if (w_idx >= c_NUM_IN_X) begin
                w_idx = w_idx - c_NUM_IN_X;
            end
            if (w_ereq[w_idx[c_PTR_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_ptr_next = (w_win == c_LAST_IDX) ? '0 : w_win + 1'b1;
    assign w_grant    = (r_state == c_ST_IDLE) && w_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_buf_clear <= '0;
            r_so        <= 1'b0;
            r_datao     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_datao     <= w_slice[w_win];
                        r_buf_clear <= NUM_IN'(1) << w_win;
                        r_ptr       <= w_ptr_next;
                        r_state     <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    // The clear pulse lasts only the first HOLD cycle.
                    r_buf_clear <= '0;
                    if (ro) begin
                        r_so    <= 1'b1;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    // datao intentionally keeps the last flit.
                    r_so    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_buf_clear <= '0;
                    r_so        <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign buf_clear = r_buf_clear;
    assign so        = r_so;
    assign datao     = r_datao;
    assign busy      = (r_state != c_ST_IDLE);

`ifdef OUTARB_GRANT_STATS_EN
    logic [15:0] r_grant_cnt [NUM_IN];

    for (gi = 0; gi < NUM_IN; gi++) begin : g_stats
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_grant_cnt[gi] <= '0;
            end else if (w_grant && (w_win == c_PTR_W'(gi)) &&
                         (r_grant_cnt[gi] != 16'hFFFF)) begin
                r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
            end
        end
        assign grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
    end
`else
    // Grant event only feeds the statistics counters.
    logic w_unused_grant;
    assign w_unused_grant = w_grant;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_output_arbiter
// Purpose  : Self-checking bench for noc_output_arbiter. Two instances share
//            stimulus: one unmasked, one with input L masked. A transaction
//            level reference model predicts every output each cycle.
// Options  : OUTARB_GRANT_STATS_EN - also checks the grant counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_output_arbiter;

    localparam int DW = 64;
    localparam int N  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] datai = '0;
    logic          ro = 1'b0;

    logic [N-1:0]  bc0, bc1;
    logic          so0, so1;
    logic [DW-1:0] do0, do1;
    logic          busy0, busy1;
`ifdef OUTARB_GRANT_STATS_EN
    logic [N*16-1:0] gc0, gc1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .UTURN_MASK(5'b00000)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .datai(datai), .ro(ro),
        .buf_clear(bc0), .so(so0), .datao(do0), .busy(busy0)
`ifdef OUTARB_GRANT_STATS_EN
        , .grant_cnt(gc0)
`endif
    );

    noc_output_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .UTURN_MASK(5'b00001)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .datai(datai), .ro(ro),
        .buf_clear(bc1), .so(so1), .datao(do1), .busy(busy1)
`ifdef OUTARB_GRANT_STATS_EN
        , .grant_cnt(gc1)
`endif
    );

    // Reference model, one entry per instance.
    // phase: 0 idle, 1 first hold cycle, 2 later hold cycles, 3 sending
    logic [N-1:0]  m_mask  [2] = '{5'b00000, 5'b00001};
    int            m_ptr   [2];
    int            m_phase [2];
    int            m_win   [2];
    logic [DW-1:0] m_data  [2];
    int            m_cnt   [2][N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]   = 0;
            m_phase[d] = 0;
            m_win[d]   = 0;
            m_data[d]  = '0;
            for (int k = 0; k < N; k++) m_cnt[d][k] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        logic [N-1:0] ereq;
        int idx;
        bit found;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            case (m_phase[d])
                0: begin
                    ereq  = req & ~m_mask[d];
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr[d] + k) % N;
                        if (!found && ereq[idx]) begin
                            found    = 1'b1;
                            m_win[d] = idx;
                        end
                    end
                    if (found) begin
                        m_data[d]  = datai[m_win[d]*DW +: DW];
                        m_ptr[d]   = (m_win[d] + 1) % N;
                        m_phase[d] = 1;
                        if (m_cnt[d][m_win[d]] < 65535) m_cnt[d][m_win[d]]++;
                    end
                end
                1, 2: m_phase[d] = ro ? 3 : 2;
                default: m_phase[d] = 0;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_bc;
        for (int d = 0; d < 2; d++) begin
            exp_bc = (m_phase[d] == 1) ? (N'(1) << m_win[d]) : '0;
            if (d == 0) begin
                check({tag, " d0 buf_clear"}, 64'(bc0), 64'(exp_bc));
                check({tag, " d0 so"}, 64'(so0), 64'(m_phase[d] == 3));
                check({tag, " d0 datao"}, do0, m_data[d]);
                check({tag, " d0 busy"}, 64'(busy0), 64'(m_phase[d] != 0));
            end else begin
                check({tag, " d1 buf_clear"}, 64'(bc1), 64'(exp_bc));
                check({tag, " d1 so"}, 64'(so1), 64'(m_phase[d] == 3));
                check({tag, " d1 datao"}, do1, m_data[d]);
                check({tag, " d1 busy"}, 64'(busy1), 64'(m_phase[d] != 0));
            end
        end
    endtask

    // Inputs are applied at the falling edge; outputs checked at the next one.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) datai[k*DW +: DW] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;
    endtask

    initial begin
        int q_grant [$];
        int exp_order [6] = '{0, 1, 2, 3, 4, 0};
        int n_pulse;

        model_reset();
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;

        // Single request from U.
        rand_data();
        req = 5'b00100;
        datai[2*DW +: DW] = 64'hC000_1000_0000_1111;
        ro = 1'b1;
        cycle("single grant");
        check("single bc const", 64'(bc0), 64'h04);
        req = '0;
        rand_data();
        cycle("single send");
        check("single so const", 64'(so0), 64'h1);
        check("single datao const", do0, 64'hC000_1000_0000_1111);
        cycle("single idle");
        check("single busy const", 64'(busy0), 64'h0);

        // Round-robin fairness with all inputs requesting.
        do_reset();
        req = 5'b11111;
        ro  = 1'b1;
        for (int c = 0; c < 18; c++) begin
            rand_data();
            cycle("fair");
            if (bc0 != '0) begin
                check("fair onehot", 64'($countones(bc0)), 64'h1);
                for (int k = 0; k < N; k++) if (bc0[k]) q_grant.push_back(k);
            end
        end
        check("fair grant count", 64'(q_grant.size()), 64'd6);
        for (int g = 0; g < 6; g++) begin
            if (g < q_grant.size()) check("fair order", 64'(q_grant[g]), 64'(exp_order[g]));
        end

        // Backpressure: L requests, downstream not ready for 10 cycles.
        do_reset();
        n_pulse = 0;
        req = 5'b00001;
        ro  = 1'b0;
        rand_data();
        cycle("bp grant");
        n_pulse += (bc0 != '0);
        check("bp masked idle", 64'(busy1), 64'h0);
        req = '0;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            cycle("bp hold");
            n_pulse += (bc0 != '0);
        end
        ro = 1'b1;
        cycle("bp send");
        check("bp so const", 64'(so0), 64'h1);
        ro = 1'b0;
        cycle("bp idle");
        check("bp pulses", 64'(n_pulse), 64'h1);

        // Mask: L and R request; masked instance must choose R.
        req = 5'b00011;
        ro  = 1'b1;
        rand_data();
        cycle("mask grant");
        check("mask bc const", 64'(bc1), 64'h02);
        req = '0;
        cycle("mask send");
        cycle("mask idle");

        // Reset while in HOLD.
        req = 5'b01000;
        ro  = 1'b0;
        rand_data();
        cycle("mid grant");
        req = '0;
        cycle("mid hold");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("mid so", 64'(so0), 64'h0);
        check("mid bc", 64'(bc0), 64'h0);
        check("mid busy", 64'(busy0), 64'h0);
        check("mid datao", do0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        req = 5'b11111;
        ro  = 1'b1;
        rand_data();
        cycle("post reset");
        check("post reset ptr0", 64'(bc0), 64'h01);
        req = '0;
        cycle("post send");
        cycle("post idle");

        // Grants to PE three times and L once.
        do_reset();
        ro = 1'b1;
        req = 5'b10000;
        for (int c = 0; c < 9; c++) begin
            rand_data();
            cycle("stats pe");
        end
        req = 5'b00001;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cycle("stats l");
        end
        req = '0;
        cycle("stats idle");
`ifdef OUTARB_GRANT_STATS_EN
        for (int k = 0; k < N; k++) begin
            check("stats d0 cnt", 64'(gc0[k*16 +: 16]),
                  (k == 4) ? 64'd3 : ((k == 0) ? 64'd1 : 64'd0));
        end
`endif

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            ro  = ($urandom_range(0, 3) != 0);
            rand_data();
            cycle("rand");
        end
`ifdef OUTARB_GRANT_STATS_EN
        for (int k = 0; k < N; k++) begin
            check("rand d0 cnt", 64'(gc0[k*16 +: 16]), 64'(m_cnt[0][k]));
            check("rand d1 cnt", 64'(gc1[k*16 +: 16]), 64'(m_cnt[1][k]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- One per router output port (L, R, U, D, PE). Shares the port between the five input interfaces using round-robin arbitration.
- Latches the winning input's flit into a single-entry output register.
- Pulses that input's buffer-clear line so the input can accept a new flit.
- Forwards the flit downstream with an si/ri-style send/ready handshake.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- NUM_IN, 5, number of requesting inputs; index order 0=L, 1=R, 2=U, 3=D, 4=PE.
- UTURN_MASK, 5'b00000, per-input request mask; bit k=1 means input k is never granted (blocks U-turns).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_IN  bit k: input k holds a flit routed to this port.
- datai  input  NUM_IN*DATA_WIDTH  flit bus; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ro  input  1  downstream ready; 1 = downstream buffer empty.
- buf_clear  output  NUM_IN  one-hot, one-cycle pulse to the granted input.
- so  output  1  send strobe to downstream, one cycle long.
- datao  output  DATA_WIDTH  held flit, valid while state is HOLD or SEND.
- busy  output  1  1 when state is not IDLE.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, ptr=0.
- buf_clear=0, so=0, datao=0, busy=0.
- A flit held at reset is dropped and buf_clear is not re-issued.

Effective request:
- ereq = req & ~UTURN_MASK.

Arbitration (state IDLE only):
- Search ereq starting at index ptr, ascending, wrapping NUM_IN-1 to 0. The first set bit is winner w.
- If ereq=0, stay in IDLE with all outputs at 0.

State machine (IDLE, HOLD, SEND):
- IDLE to HOLD, at the edge where ereq!=0:
  - datao <= datai slice w.
  - buf_clear <= one-hot(w).
  - ptr <= (w+1) mod NUM_IN.
- HOLD:
  - buf_clear is high for the first HOLD cycle only, then returns to 0.
  - datao is held stable.
  - On an edge with ro=1 (the first HOLD cycle counts): so <= 1, go to SEND.
  - While ro=0, stay in HOLD indefinitely with no timeout.
- SEND:
  - so=1 for exactly this cycle; datao unchanged.
  - Next edge: so <= 0, go to IDLE. datao keeps its last value; do not clear it.

Latency and throughput:
- req sampled at edge n gives buf_clear high during cycle n+1.
- With ro=1, so is high during cycle n+2.
- Minimum of 3 cycles per flit per port.

Boundary rules:
- req is ignored outside IDLE; no grant queueing.
- The old winner's req is expected low by the next IDLE (it falls after buf_clear). If it is still high, it is treated as a new flit.
- Simultaneous requests on all inputs are served in order ptr, ptr+1, … so each input gets one grant per NUM_IN grants.
- ptr wraps from 4 to 0.
- ro toggling during SEND has no effect.
- X/garbage on datai slices of non-winning inputs must not reach datao.
- Outputs are registered; no combinational path from req/ro to outputs.

Optional Feature:
Macro OUTARB_GRANT_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_IN*16 bits), one 16-bit counter per input.
  - A counter increments on each IDLE-to-HOLD grant to that input and saturates at 16'hFFFF.
  - Counters reset to 0 on rst=0.
- Undefined:
  - Port and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: reset, then req=5'b00100, datai[U]=64'hC000_1000_0000_1111 (datai[U] = slice 2 of datai, U=index 2), ro=1 → buf_clear=5'b00100 for 1 cycle, then so=1 for 1 cycle with datao=64'hC000_1000_0000_1111, then busy=0.
- Round-robin fairness: req=5'b11111 held and re-asserted after every grant, ro=1 → grant order 0,1,2,3,4,0; exactly one buf_clear bit high per grant.
- Backpressure: req=5'b00001, ro=0 for 10 cycles then 1 → buf_clear pulse exactly once; so stays 0 while ro=0; so goes to 1 on the cycle after ro rises; datao stable throughout.
- Mask: UTURN_MASK=5'b00001, req=5'b00001 → no buf_clear, busy=0. Then req=5'b00011 → only input 1 is granted.
- Reset mid-operation: drive rst low while in HOLD → so, buf_clear, busy and datao go to 0 immediately. After release, the next grant starts at ptr=0.
- Stats (OUTARB_GRANT_STATS_EN): 3 grants to PE (index 4), 1 grant to L (index 0) → grant_cnt[PE]=3, grant_cnt[L]=1, all others 0.
